// File: rtl/ibus_sram_responder.sv
// Fetch-side instruction bus responder: issues single-beat word reads on an
// SRAM-like port, holds the last word in a one-entry buffer and stalls fetch until it hits.
module ibus_sram_responder #(
   parameter logic [31:0] NOP_WORD = 32'h00000000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] ibus_addr,
   input  logic        ibus_read,
   output logic [31:0] ibus_rdata,
   output logic        ibus_stall,
   input  logic        flush,
   output logic        inst_req,
   output logic        inst_wr,
   output logic [1:0]  inst_size,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t      state, state_n;
   logic [31:0] req_addr, req_addr_n;
   logic        drop, drop_n;
   logic        buf_valid, buf_valid_n;
   logic [31:0] buf_addr, buf_addr_n;
   logic [31:0] buf_data, buf_data_n;
   logic        hit, misaligned, need;

   assign inst_wr    = 1'b0;
   assign inst_size  = 2'b10;
   assign hit        = resetn && buf_valid && (buf_addr == ibus_addr);
   assign misaligned = (ibus_addr[1:0] != 2'b00);
   assign need       = resetn && ibus_read && !hit && !misaligned && !flush;
   assign ibus_rdata = hit ? buf_data : NOP_WORD;

   always_comb begin
      state_n     = state;
      req_addr_n  = req_addr;
      drop_n      = drop;
      buf_valid_n = buf_valid;
      buf_addr_n  = buf_addr;
      buf_data_n  = buf_data;
      inst_req    = 1'b0;
      inst_addr   = req_addr;
      ibus_stall  = ibus_read && !misaligned && !hit && !flush;
      unique case (state)
         IDLE: begin
            inst_req  = need;
            inst_addr = ibus_addr;
            if (need) begin
               req_addr_n = ibus_addr;
               drop_n     = 1'b0;
               state_n    = inst_addr_ok ? WAIT : REQ;
            end
         end
         REQ: begin
            // a presented request stays up; a flush seen meanwhile only marks it stale
            inst_req   = 1'b1;
            ibus_stall = 1'b1;
            drop_n     = drop | flush;
            if (inst_addr_ok) begin
               state_n = (drop || flush) ? DROP : WAIT;
               drop_n  = 1'b0;
            end
         end
         WAIT: begin
            ibus_stall = !flush;
            if (inst_data_ok) begin
               state_n = IDLE;
               if (flush) begin
                  buf_valid_n = 1'b0;
               end else begin
                  buf_valid_n = 1'b1;
                  buf_addr_n  = req_addr;
                  buf_data_n  = inst_rdata;
               end
            end else if (flush) begin
               state_n = DROP;
            end
         end
         DROP: begin
            ibus_stall = 1'b1;
            if (inst_data_ok) begin
               buf_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (!resetn) begin
         inst_req   = 1'b0;
         ibus_stall = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state     <= IDLE;
         req_addr  <= '0;
         drop      <= 1'b0;
         buf_valid <= 1'b0;
         buf_addr  <= '0;
         buf_data  <= '0;
      end else begin
         state     <= state_n;
         req_addr  <= req_addr_n;
         drop      <= drop_n;
         buf_valid <= buf_valid_n;
         buf_addr  <= buf_addr_n;
         buf_data  <= buf_data_n;
      end
   end

endmodule

// File: tb/tb_ibus_sram_responder.sv
// Directed bench for ibus_sram_responder: reset, miss latency, delayed accept,
// flush before and with data_ok, misaligned fetch.
module tb_ibus_sram_responder;

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] ibus_addr;
   logic        ibus_read;
   logic [31:0] ibus_rdata;
   logic        ibus_stall;
   logic        flush;
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   int unsigned total = 0;
   int unsigned fails = 0;

   ibus_sram_responder #(.NOP_WORD(32'h00000000)) dut (
      .clock(clock), .resetn(resetn),
      .ibus_addr(ibus_addr), .ibus_read(ibus_read), .ibus_rdata(ibus_rdata),
      .ibus_stall(ibus_stall), .flush(flush),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs are changed 1 time unit after the edge, outputs checked 2 units later
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic outs(input string tag, input logic req, input logic stall, input logic [31:0] rd);
      #2;
      chk({tag, ".req"}, {31'b0, inst_req}, {31'b0, req});
      chk({tag, ".stall"}, {31'b0, ibus_stall}, {31'b0, stall});
      chk({tag, ".rdata"}, ibus_rdata, rd);
   endtask

   initial begin
      resetn = 1'b0; ibus_read = 1'b1; ibus_addr = 32'hbfc00000; flush = 1'b0;
      inst_addr_ok = 1'b1; inst_data_ok = 1'b0; inst_rdata = 32'h0;

      // 1: reset held two cycles
      tick(); outs("rst1", 1'b0, 1'b0, 32'h0);
      chk("rst1.wr", {31'b0, inst_wr}, 32'h0);
      chk("rst1.size", {30'b0, inst_size}, 32'h2);
      tick(); outs("rst2", 1'b0, 1'b0, 32'h0);

      // 2: zero-wait accept, data one cycle later
      tick(); resetn = 1'b1;
      outs("m1.c0", 1'b1, 1'b1, 32'h0);
      chk("m1.c0.addr", inst_addr, 32'hbfc00000);
      tick(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3c1d8001;
      outs("m1.c1", 1'b0, 1'b1, 32'h0);
      tick(); inst_data_ok = 1'b0; inst_rdata = 32'h0;
      outs("m1.c2", 1'b0, 1'b0, 32'h3c1d8001);

      // flush in IDLE keeps the buffer
      flush = 1'b1;
      outs("fidle", 1'b0, 1'b0, 32'h3c1d8001);
      tick(); flush = 1'b0;
      outs("fidle2", 1'b0, 1'b0, 32'h3c1d8001);

      // 3: accept delayed three cycles
      ibus_addr = 32'hbfc00004;
      outs("m2.c0", 1'b1, 1'b1, 32'h0);
      chk("m2.c0.addr", inst_addr, 32'hbfc00004);
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i == 3) inst_addr_ok = 1'b1;
         inst_data_ok = 1'b1; inst_rdata = 32'h55555555;  // data_ok in REQ must be ignored
         outs($sformatf("m2.c%0d", i), 1'b1, 1'b1, 32'h0);
         chk($sformatf("m2.c%0d.addr", i), inst_addr, 32'hbfc00004);
      end
      tick(); inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
      outs("m2.c4", 1'b0, 1'b1, 32'h0);
      inst_data_ok = 1'b1; inst_rdata = 32'h24080001;
      tick(); inst_data_ok = 1'b0; inst_rdata = 32'h0;
      outs("m2.c5", 1'b0, 1'b0, 32'h24080001);

      // 4: flush in WAIT before data returns
      ibus_addr = 32'hbfc00008; inst_addr_ok = 1'b1;
      outs("f1.c0", 1'b1, 1'b1, 32'h0);
      tick(); inst_addr_ok = 1'b0; flush = 1'b1; ibus_addr = 32'hbfc00100;
      outs("f1.c1", 1'b0, 1'b0, 32'h0);
      tick(); flush = 1'b0;
      outs("f1.c2", 1'b0, 1'b1, 32'h0);
      inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef;
      outs("f1.c2d", 1'b0, 1'b1, 32'h0);
      tick(); inst_data_ok = 1'b0; inst_rdata = 32'h0;
      outs("f1.c3", 1'b1, 1'b1, 32'h0);
      chk("f1.c3.addr", inst_addr, 32'hbfc00100);

      // 5: flush coincident with data_ok
      inst_addr_ok = 1'b1;
      tick(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; flush = 1'b1; inst_rdata = 32'h11111111;
      outs("f2.c1", 1'b0, 1'b0, 32'h0);
      tick(); inst_data_ok = 1'b0; flush = 1'b0; inst_rdata = 32'h0;
      outs("f2.c2", 1'b1, 1'b1, 32'h0);

      // 6: misaligned fetch never requests
      ibus_addr = 32'hbfc00002;
      outs("mis.c0", 1'b0, 1'b0, 32'h0);
      inst_data_ok = 1'b1; inst_rdata = 32'h77777777;
      tick();
      outs("mis.c1", 1'b0, 1'b0, 32'h0);
      inst_data_ok = 1'b0;
      tick();
      outs("mis.c2", 1'b0, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/ibus_sram_responder.md
Name: ibus_sram_responder

Overview:
Instruction-bus responder facing the fetch stage. It accepts the fetch stage's per-cycle ibus_addr/ibus_read, issues single-beat word reads on an SRAM-like instruction port, and returns the instruction word. It requests a pipeline stall until the word for the current fetch address is held in its one-entry buffer. In-flight responses made stale by a branch or exception are discarded.

Parameters:
NOP_WORD, 32'h00000000, value driven on ibus_rdata whenever the buffer does not hold the current fetch address.

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  synchronous active-low reset
ibus_addr  in  32  fetch address from the fetch stage
ibus_read  in  1  fetch request valid this cycle
ibus_rdata  out  32  instruction word for ibus_addr
ibus_stall  out  1  stall request to the stall controller; fetch holds ibus_addr while this is 1
flush  in  1  branch/exception redirect; any outstanding response is stale
inst_req  out  1  memory request
inst_wr  out  1  tied 0
inst_size  out  2  tied 2'b10 (word)
inst_addr  out  32  memory request address
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  read data valid this cycle
inst_rdata  in  32  read data

Behaviour:
- Reset is synchronous (resetn=0 sampled at the clock edge):
  - state=IDLE, buf_valid=0, buf_addr=0, buf_data=0.
  - Outputs during and after reset: inst_req=0, ibus_stall=0, ibus_rdata=NOP_WORD.
- hit = buf_valid && buf_addr==ibus_addr.
- misaligned = ibus_addr[1:0]!=0. The fetch stage raises the address-error exception for these; this block never issues a request for a misaligned address.
- need = ibus_read && !hit && !misaligned && !flush.
- ibus_rdata = hit ? buf_data : NOP_WORD (combinational).
- ibus_stall = ibus_read && !misaligned && !hit (combinational), with two exceptions:
  - forced 0 while flush=1;
  - forced 1 in states REQ, WAIT and DROP, except that in WAIT it is 0 for a cycle in which flush=1.
- States:
  - IDLE: inst_req=need, inst_addr=ibus_addr.
    - need && inst_addr_ok: latch req_addr=ibus_addr, go to WAIT.
    - need && !inst_addr_ok: latch req_addr, go to REQ.
  - REQ: inst_req=1, inst_addr=req_addr, held stable until accepted.
    - inst_addr_ok: go to WAIT, or to DROP if flush is seen this cycle or earlier while in REQ (recorded in a sticky drop bit).
    - A request already presented is never withdrawn.
  - WAIT: inst_req=0.
    - inst_data_ok && !flush: buf_data=inst_rdata, buf_addr=req_addr, buf_valid=1, go to IDLE.
    - flush && !inst_data_ok: go to DROP.
    - flush && inst_data_ok: discard data, buf_valid=0, go to IDLE.
  - DROP: inst_req=0. On inst_data_ok, discard data, set buf_valid=0, go to IDLE.
- Latency on a miss:
  - Request in the cycle the miss is seen; inst_data_ok no earlier than the cycle after inst_addr_ok.
  - Buffer is written at the data_ok edge; ibus_stall falls in the following cycle, with ibus_rdata valid in that same cycle.
  - Minimum stall is 2 cycles when addr_ok arrives with req and data_ok one cycle later.
- At most one outstanding request. inst_data_ok while in IDLE or REQ is ignored.
- flush in IDLE clears nothing; the buffer stays valid, since a redirect to the same address may hit.
- Sequential fetch (addr+4) always misses. The buffer serves only repeated fetches of a stalled address.
- Reset mid-transaction returns to IDLE immediately. A data_ok that arrives after reset is ignored in IDLE.

Test Plan:
1. Reset with resetn=0 for 2 cycles, ibus_read=1, addr=32'hbfc00000 -> inst_req=0, ibus_stall=0, ibus_rdata=0 during reset.
2. Fetch 32'hbfc00000; addr_ok in the same cycle; data_ok one cycle later with rdata=32'h3c1d8001 -> inst_req for 1 cycle at addr bfc00000; stall for 2 cycles; next cycle rdata=3c1d8001 and stall=0.
3. addr_ok delayed 3 cycles -> inst_req and inst_addr held stable for 4 cycles; stall continuous until the cycle after data_ok.
4. flush pulsed in WAIT before data_ok=32'hdeadbeef, with ibus_addr now 32'hbfc00100 -> beef discarded, buf_valid=0; a new request issued for bfc00100 on return to IDLE; ibus_rdata never shows deadbeef.
5. flush coincident with data_ok -> data discarded, state IDLE, no extra request that cycle.
6. ibus_addr=32'hbfc00002 with ibus_read=1 -> inst_req=0, ibus_stall=0, ibus_rdata=NOP_WORD.
